hilo_div_unit: RTL
==================

Name: hilo_div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the execute stage, directly downstream of the datapath's divider hook.
- Consumes SrcAE/SrcBE for DIV/DIVU.
- Result {remainder, quotient} feeds the HI/LO write path (hi = remainder, lo = quotient).
- Datapath stalls F/D/E while start_i && !ready_o.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W bits.
ITER_W, 6, iteration counter width; must hold DATA_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
opdata1_i  input  DATA_W  dividend; sampled at accept
opdata2_i  input  DATA_W  divisor; sampled at accept
start_i  input  1  level request; held high by the datapath until it consumes the result
annul_i  input  1  abort in-flight division (flush/exception)
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered
ready_o  output  1  result valid; registered

Behaviour:
- Reset (rst=0, async): state=FREE, counter=0, result_o=0, ready_o=0, working regs=0. Applies mid-operation; no partial result survives.
- States: FREE, DIVBYZERO, ON, END.
- FREE:
  - start_i=1 && annul_i=0 && divisor==0 -> DIVBYZERO.
  - start_i=1 && annul_i=0 && divisor!=0 -> ON. On the same edge (accept edge E0), latch operand magnitudes (two's-complement negation when signed_div_i=1 and operand bit31=1), both sign bits, signed flag; clear counter and partial remainder.
  - Otherwise stay in FREE. ready_o=0, result_o=0.
- DIVBYZERO: next edge -> END; result_o=0, ready_o=1.
- ON, one iteration per edge:
  - Shift {partial_rem, dividend} left 1.
  - Trial-subtract divisor (DATA_W+1-bit compare).
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - Counter increments 0..31.
  - On the edge completing iteration 32 (E32): apply sign fix-up, load result_o, set ready_o=1, go to END.
  - Latency: ready_o high in the cycle after E32, i.e. 32 cycles after the accept edge.
- Sign fix-up (signed only):
  - Quotient negated iff dividend sign != divisor sign.
  - Remainder negated iff dividend sign = 1.
  - Unsigned: no fix-up.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000 (wraps), remainder 0; no trap.
- annul_i=1 in ON or DIVBYZERO: next edge -> FREE, ready_o=0, result_o=0, counter=0. annul_i has priority over start_i and completion on the same edge.
- END: hold result_o, ready_o=1 while start_i=1.
  - start_i=0 -> FREE; ready_o and result_o clear on that edge.
  - annul_i=1 in END -> FREE.
- Operand changes after the accept edge are ignored.
- start_i dropping while in ON does not abort; only annul_i or reset abort.
- Back-to-back divides: at least one FREE cycle between results, because start_i must drop for END -> FREE.
- No combinational path from any input to any output.

Test Plan:
1. Unsigned: opdata1=100, opdata2=7, signed=0, start=1 held -> ready_o=0 for 32 cycles after accept, then ready_o=1, result_o={32'd2, 32'd14}; drop start -> ready_o=0, result_o=0 next cycle.
2. Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2, signed=1 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; also 7/-2 -> {0x00000001, 0xFFFFFFFD}; also 0xFFFFFFF9 / 2 unsigned -> {0x00000001, 0x7FFFFFFC}.
3. Divide by zero: opdata1=5, opdata2=0 -> ready_o=1 two edges after start is sampled (FREE->DIVBYZERO->END), result_o=0.
4. Signed overflow: 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000, 0x80000000} after 32 cycles.
5. Annul: start 100/7, assert annul_i for one cycle at iteration 10 -> ready_o never rises, state returns to FREE; subsequent 9/3 completes in 32 cycles with {0, 3}.
6. Reset: pull rst low at iteration 20 -> ready_o=0, result_o=0 immediately (asynchronously); after release, idle in FREE until start_i; a fresh 100/7 completes normally.

Source files
------------

// File: rtl/hilo_div_unit.sv
// -----------------------------------------------------------------------------
// hilo_div_unit
//
// Multi-cycle radix-2 restoring divider for the execute stage. A DIV/DIVU
// request is accepted from FREE when start_i is high. The unit then runs one
// quotient bit per clock and returns {remainder, quotient} for the HI/LO write
// path (hi = remainder, lo = quotient). The datapath holds start_i high and
// stalls until ready_o rises, then drops start_i to release the unit.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (0 = reset)
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled at accept
//   opdata1_i     dividend; sampled at accept
//   opdata2_i     divisor; sampled at accept
//   start_i       level request, held until the result is consumed
//   annul_i       abort an in-flight divide (flush / exception)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
// -----------------------------------------------------------------------------
module hilo_div_unit #(
    parameter int DATA_W = 32,
    parameter int ITER_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        DIVBYZERO = 2'd1,
        ON        = 2'd2,
        END       = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ITER_W-1:0]     cnt_reg, cnt_next;
    logic [DATA_W-1:0]     rem_reg, rem_next;     // partial remainder
    logic [DATA_W-1:0]     quo_reg, quo_next;     // dividend bits shifting out, quotient bits shifting in
    logic [DATA_W-1:0]     dvs_reg, dvs_next;     // divisor magnitude
    logic                  sign1_reg, sign1_next; // dividend sign bit
    logic                  sign2_reg, sign2_next; // divisor sign bit
    logic                  signed_reg, signed_next;
    logic [2*DATA_W-1:0]   result_reg, result_next;
    logic                  ready_reg, ready_next;

    // -------------------------------------------------------------------------
    // Operand magnitudes: index 0 = dividend, 1 = divisor. A negative signed
    // operand is two's-complement negated; the most negative value maps onto
    // itself, which is still the correct magnitude when read as unsigned.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] op_in  [2];
    logic [DATA_W-1:0] op_mag [2];
    logic              op_neg [2];

    assign op_in[0] = opdata1_i;
    assign op_in[1] = opdata2_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            assign op_neg[gi] = signed_div_i & op_in[gi][DATA_W-1];
            assign op_mag[gi] = op_neg[gi] ? ({DATA_W{1'b0}} - op_in[gi]) : op_in[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // One restoring iteration. The partial remainder is always below the
    // divisor, so the shifted value needs one extra bit; the trial difference
    // carries one more bit so its MSB acts as the borrow / sign.
    // -------------------------------------------------------------------------
    logic [DATA_W:0]   shifted_rem;
    logic [DATA_W+1:0] trial_diff;
    logic              trial_ok;
    logic [DATA_W-1:0] iter_rem;
    logic [DATA_W-1:0] iter_quo;
    logic              last_iter;

    assign shifted_rem = {rem_reg, quo_reg[DATA_W-1]};
    assign trial_diff  = {1'b0, shifted_rem} - {2'b00, dvs_reg};
    assign trial_ok    = ~trial_diff[DATA_W+1];
    assign iter_rem    = trial_ok ? trial_diff[DATA_W-1:0] : shifted_rem[DATA_W-1:0];
    assign iter_quo    = {quo_reg[DATA_W-2:0], trial_ok};
    assign last_iter   = (cnt_reg == ITER_W'(DATA_W - 1));

    // Sign fix-up applied on the final iteration's outputs.
    logic              neg_quo;
    logic              neg_rem;
    logic [DATA_W-1:0] fix_quo;
    logic [DATA_W-1:0] fix_rem;

    assign neg_quo = signed_reg & (sign1_reg ^ sign2_reg);
    assign neg_rem = signed_reg & sign1_reg;
    assign fix_quo = neg_quo ? ({DATA_W{1'b0}} - iter_quo) : iter_quo;
    assign fix_rem = neg_rem ? ({DATA_W{1'b0}} - iter_rem) : iter_rem;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= FREE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            signed_reg <= 1'b0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dvs_reg    <= dvs_next;
            sign1_reg  <= sign1_next;
            sign2_reg  <= sign2_next;
            signed_reg <= signed_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. annul_i is tested first in every busy
    // state so it wins over both start_i and completion.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dvs_next    = dvs_reg;
        sign1_next  = sign1_reg;
        sign2_next  = sign2_reg;
        signed_next = signed_reg;
        result_next = result_reg;
        ready_next  = ready_reg;

        case (state_reg)
            FREE: begin
                result_next = '0;
                ready_next  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DIVBYZERO;
                    end else begin
                        state_next  = ON;
                        quo_next    = op_mag[0];
                        dvs_next    = op_mag[1];
                        sign1_next  = opdata1_i[DATA_W-1];
                        sign2_next  = opdata2_i[DATA_W-1];
                        signed_next = signed_div_i;
                        cnt_next    = '0;
                        rem_next    = '0;
                    end
                end
            end

            DIVBYZERO: begin
                result_next = '0;
                cnt_next    = '0;
                if (annul_i) begin
                    state_next = FREE;
                    ready_next = 1'b0;
                end else begin
                    state_next = END;
                    ready_next = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_next  = FREE;
                    ready_next  = 1'b0;
                    result_next = '0;
                    cnt_next    = '0;
                end else begin
                    rem_next = iter_rem;
                    quo_next = iter_quo;
                    cnt_next = cnt_reg + 1'b1;
                    if (last_iter) begin
                        state_next  = END;
                        result_next = {fix_rem, fix_quo};
                        ready_next  = 1'b1;
                        cnt_next    = '0;
                    end
                end
            end

            END: begin
                if (annul_i || !start_i) begin
                    state_next  = FREE;
                    ready_next  = 1'b0;
                    result_next = '0;
                end
            end

            default: begin
                state_next  = FREE;
                ready_next  = 1'b0;
                result_next = '0;
                cnt_next    = '0;
            end
        endcase
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule
